// File: rtl/phase_pkg.sv
`default_nettype none
// ============================================================================
// phase_pkg : shared widths and switch-FSM state type for the phase selector
// Revision  : 1.0
// ============================================================================
package phase_pkg;

    localparam int PHASE_W    = 2;
    localparam int NUM_PHASES = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        HOLD  = 2'd2
    } sw_state_t;

endpackage
`default_nettype wire

// File: rtl/phase_gen.sv
`default_nettype none
// ============================================================================
// phase_gen : quadrature counter, four divide-by-4 phase waveforms, strobes
// Revision  : 1.0
// ============================================================================
module phase_gen
    import phase_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    output logic [PHASE_W-1:0]    cnt,
    output logic [NUM_PHASES-1:0] t,
    output logic [NUM_PHASES-1:0] phase_strobe
);

    logic [PHASE_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign cnt = r_cnt;

    generate
        for (genvar k = 0; k < NUM_PHASES; k++) begin : g_wave
            logic [PHASE_W-1:0] w_rel;
            assign w_rel = r_cnt - PHASE_W'(k);
            // (cnt - k) mod 4 < 2 is exactly "bit 1 of the difference is clear"
            assign t[k]            = ~w_rel[1];
            assign phase_strobe[k] = (r_cnt == PHASE_W'(k));
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/phase_switch_ctrl.sv
`default_nettype none
// ============================================================================
// phase_switch_ctrl : glitch-free run-time selector for four quadrature phases
// Revision          : 1.0
// ============================================================================
module phase_switch_ctrl
    import phase_pkg::*;
#(
    parameter int RESET_PHASE = 0,
    parameter int MIN_LOW     = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req,
    input  logic [PHASE_W-1:0]    req_phase,
    output logic                  clk_out,
    output logic [PHASE_W-1:0]    cur_phase,
    output logic                  busy,
    output logic                  ack,
    output logic [NUM_PHASES-1:0] phase_strobe
);

    localparam logic [PHASE_W-1:0] c_reset_phase = PHASE_W'(RESET_PHASE);
    localparam logic [2:0]         c_min_low     = 3'(MIN_LOW);

    logic [PHASE_W-1:0]    w_cnt;
    logic [NUM_PHASES-1:0] w_t;
    logic                  w_t_cur;
    logic                  w_aligned;

    sw_state_t             r_state;
    logic                  r_en;
    logic                  r_clk_out;
    logic                  r_busy;
    logic                  r_ack;
    logic [PHASE_W-1:0]    r_cur;
    logic [PHASE_W-1:0]    r_new;
    logic [2:0]            r_lowcnt;

    phase_gen u_gen (
        .clk          (clk),
        .rst          (rst),
        .cnt          (w_cnt),
        .t            (w_t),
        .phase_strobe (phase_strobe)
    );

    assign w_t_cur   = w_t[r_cur];
    // New phase starts exactly at its rising point so its first high is full width
    assign w_aligned = (w_cnt == r_new);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_en      <= 1'b1;
            r_clk_out <= 1'b0;
            r_busy    <= 1'b0;
            r_ack     <= 1'b0;
            r_cur     <= c_reset_phase;
            r_new     <= c_reset_phase;
            r_lowcnt  <= '0;
        end else begin
            r_clk_out <= r_en & w_t_cur;
            r_ack     <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (req) begin
                        if (req_phase == r_cur) begin
                            r_ack <= 1'b1;
                        end else begin
                            r_new   <= req_phase;
                            r_state <= DRAIN;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    // Gate only once the old phase is already heading low
                    if (!w_t_cur) begin
                        r_en     <= 1'b0;
                        r_lowcnt <= 3'd1;
                        r_state  <= HOLD;
                    end
                end
                HOLD: begin
                    if (r_lowcnt < c_min_low) begin
                        r_lowcnt <= r_lowcnt + 3'd1;
                    end
                    if ((r_lowcnt >= c_min_low) && w_aligned) begin
                        r_cur     <= r_new;
                        r_en      <= 1'b1;
                        r_clk_out <= 1'b1;
                        r_ack     <= 1'b1;
                        r_busy    <= 1'b0;
                        r_state   <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign clk_out   = r_clk_out;
    assign cur_phase = r_cur;
    assign busy      = r_busy;
    assign ack       = r_ack;

endmodule
`default_nettype wire

// File: tb/tb_phase_switch_ctrl.sv
`default_nettype none
// ============================================================================
// tb_phase_switch_ctrl : directed bench with schedule-based reference model
// Revision             : 1.0
// ============================================================================
module tb_phase_switch_ctrl;

    localparam int RESET_PHASE = 0;
    localparam int MIN_LOW     = 2;
    localparam int LOW_RUN_MIN = (MIN_LOW < 2) ? MIN_LOW : 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       req;
    logic [1:0] req_phase;
    logic       clk_out;
    logic [1:0] cur_phase;
    logic       busy;
    logic       ack;
    logic [3:0] phase_strobe;

    int n_tests = 0;
    int n_fail  = 0;

    phase_switch_ctrl #(
        .RESET_PHASE (RESET_PHASE),
        .MIN_LOW     (MIN_LOW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .req_phase    (req_phase),
        .clk_out      (clk_out),
        .cur_phase    (cur_phase),
        .busy         (busy),
        .ack          (ack),
        .phase_strobe (phase_strobe)
    );

    always #5 clk = ~clk;

    // Reference model: per switch, the gating edge g and exit edge x are
    // computed up front from the waveform rules, relative to the accept edge.
    int   m_cnt = 0;
    int   m_cur = RESET_PHASE;
    int   m_new, m_c0, m_rel, m_g, m_x;
    bit   m_sw    = 1'b0;
    bit   m_valid = 1'b0;
    logic m_clk, m_busy, m_ack;

    function automatic bit tw(input int k, input int c);
        return ((c - k) & 3) < 2;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        int pre = m_cnt;
        if (rst) begin
            m_cnt  = 0;
            m_cur  = RESET_PHASE;
            m_sw   = 1'b0;
            m_clk  = 1'b0;
            m_busy = 1'b0;
            m_ack  = 1'b0;
        end else begin
            m_ack = 1'b0;
            if (!m_sw) begin
                m_clk = tw(m_cur, pre);
                if (req && (int'(req_phase) == m_cur)) begin
                    m_ack = 1'b1;
                end else if (req) begin
                    m_sw  = 1'b1;
                    m_new = int'(req_phase);
                    m_c0  = pre;
                    m_rel = 0;
                    m_g   = 1;
                    while (tw(m_cur, m_c0 + m_g)) m_g++;
                    m_x = m_g + MIN_LOW;
                    while (((m_c0 + m_x - m_new) & 3) != 0) m_x++;
                end
            end else begin
                m_rel++;
                if (m_rel < m_g) begin
                    m_clk = tw(m_cur, pre);
                end else if (m_rel < m_x) begin
                    m_clk = 1'b0;
                end else begin
                    m_clk = 1'b1;
                    m_ack = 1'b1;
                    m_cur = m_new;
                    m_sw  = 1'b0;
                end
            end
            m_busy = m_sw;
            m_cnt  = (pre + 1) & 3;
        end
        m_valid = 1'b1;
    endtask

    task automatic step(input logic r, input logic q, input logic [1:0] qp);
        rst       = r;
        req       = q;
        req_phase = qp;
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    // Per-cycle comparison against the model plus pulse-width tracking
    initial begin
        int   hi_len = 0;
        int   lo_len = 0;
        forever begin
            @(negedge clk);
            if (m_valid) begin
                check("clk_out", clk_out, m_clk);
                check("cur_phase", cur_phase, m_cur);
                check("busy", busy, m_busy);
                check("ack", ack, m_ack);
                check("phase_strobe", phase_strobe, 32'd1 << m_cnt);
                if (clk_out === 1'b1) begin
                    if (lo_len > 0) check("low_run_min", lo_len >= LOW_RUN_MIN, 1);
                    lo_len = 0;
                    hi_len++;
                end else begin
                    if (hi_len > 0) check("high_run_len", hi_len, 2);
                    hi_len = 0;
                    lo_len++;
                end
            end
        end
    end

    task automatic do_switch(input int target, input int off, output int lat);
        int run     = 0;
        int max_low = 0;
        int guard   = 0;
        bit got     = 1'b0;
        while (m_cnt != off && guard < 8) begin
            step(1'b0, 1'b0, 2'd0);
            guard++;
        end
        step(1'b0, 1'b1, target[1:0]);
        lat = 0;
        for (int i = 1; i <= MIN_LOW + 10 && !got; i++) begin
            step(1'b0, 1'b0, 2'd0);
            if (clk_out === 1'b0) begin
                run++;
                if (run > max_low) max_low = run;
            end else begin
                run = 0;
            end
            if (ack === 1'b1) begin
                got = 1'b1;
                lat = i;
            end
        end
        check("switch_ack_seen", got, 1);
        check("switch_latency_ok", (got && lat <= MIN_LOW + 6), 1);
        check("switch_low_gap", max_low >= MIN_LOW, 1);
        check("switch_cur_phase", cur_phase, target);
    endtask

    initial begin
        int rel_pat[8] = '{1, 1, 0, 0, 1, 1, 0, 0};
        int sw_pat[7]  = '{1, 1, 0, 0, 0, 0, 1};
        int lat;
        int acks;
        int guard;

        rst = 1'b1; req = 1'b0; req_phase = 2'd0;
        repeat (3) step(1'b1, 1'b0, 2'd0);
        check("rst_clk_out", clk_out, 0);
        check("rst_busy", busy, 0);
        check("rst_ack", ack, 0);
        check("rst_cur_phase", cur_phase, RESET_PHASE);
        check("rst_strobe", phase_strobe, 4'b0001);

        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b0, 2'd0);
            check("post_rst_clk", clk_out, rel_pat[i]);
        end

        // 0 -> 2 accepted at cnt 0, with an ignored request while busy
        acks  = 0;
        guard = 0;
        while (m_cnt != 0 && guard < 8) begin
            step(1'b0, 1'b0, 2'd0);
            guard++;
        end
        step(1'b0, 1'b1, 2'd2);
        check("sw02_clk_accept", clk_out, sw_pat[0]);
        check("sw02_busy_after_accept", busy, 1);
        for (int i = 1; i <= 6; i++) begin
            if (i == 3) step(1'b0, 1'b1, 2'd3);
            else        step(1'b0, 1'b0, 2'd0);
            check("sw02_clk", clk_out, sw_pat[i]);
            check("sw02_ack", ack, (i == 6));
            if (ack === 1'b1) acks++;
        end
        check("sw02_cur_phase", cur_phase, 2);
        check("sw02_busy_end", busy, 0);
        repeat (6) begin
            step(1'b0, 1'b0, 2'd0);
            if (ack === 1'b1) acks++;
        end
        check("busy_req_single_ack", acks, 1);
        check("busy_req_final_cur", cur_phase, 2);

        // Same-phase request
        do_switch(1, 0, lat);
        step(1'b0, 1'b1, 2'd1);
        check("same_ack", ack, 1);
        check("same_busy", busy, 0);
        step(1'b0, 1'b0, 2'd0);
        check("same_ack_drop", ack, 0);
        check("same_busy_after", busy, 0);
        repeat (4) step(1'b0, 1'b0, 2'd0);

        // Reset while holding low
        step(1'b0, 1'b1, 2'd3);
        guard = 0;
        while (!(m_sw && m_rel >= m_g) && guard < 8) begin
            step(1'b0, 1'b0, 2'd0);
            guard++;
        end
        check("midrst_in_switch", busy, 1);
        step(1'b1, 1'b0, 2'd0);
        check("midrst_clk_out", clk_out, 0);
        check("midrst_busy", busy, 0);
        check("midrst_cur_phase", cur_phase, RESET_PHASE);
        acks = 0;
        repeat (12) begin
            step(1'b0, 1'b0, 2'd0);
            if (ack === 1'b1) acks++;
        end
        check("midrst_no_ack", acks, 0);

        // All from/to pairs at every accept offset
        for (int f = 0; f < 4; f++) begin
            for (int t = 0; t < 4; t++) begin
                if (t != f) begin
                    for (int off = 0; off < 4; off++) begin
                        if (m_cur != f) do_switch(f, m_cnt, lat);
                        do_switch(t, off, lat);
                        repeat (2) step(1'b0, 1'b0, 2'd0);
                    end
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
